ex_mdu: RTL and testbench

EX_MDU -- requirements
Module: ex_mdu

---
 rtl/ex_mdu_pkg.sv | 59 +++++
 rtl/ex_mdu_alu.sv | 41 ++++
 rtl/ex_mdu_div_iter.sv | 108 ++++++++++
 rtl/ex_mdu.sv | 194 +++++++++++++++++++
 tb/tb_ex_mdu.sv | 256 +++++++++++++++++++++++++
 5 files changed

// File: rtl/ex_mdu_pkg.sv
`default_nettype none
// ============================================================================
// Module : ex_mdu_pkg
// Brief  : Opcode/funct constants, ALU op codes and MDU FSM states.
// Rev    : 1.0
// ============================================================================
package ex_mdu_pkg;

    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    localparam logic [6:0] F7_BASE    = 7'b0000000;
    localparam logic [6:0] F7_ALT     = 7'b0100000;
    localparam logic [6:0] F7_MULDIV  = 7'b0000001;

    localparam logic [2:0] F3_ADD     = 3'b000;
    localparam logic [2:0] F3_SLL     = 3'b001;
    localparam logic [2:0] F3_SLT     = 3'b010;
    localparam logic [2:0] F3_SLTU    = 3'b011;
    localparam logic [2:0] F3_XOR     = 3'b100;
    localparam logic [2:0] F3_SR      = 3'b101;
    localparam logic [2:0] F3_OR      = 3'b110;
    localparam logic [2:0] F3_AND     = 3'b111;

    localparam logic [2:0] F3_MUL     = 3'b000;
    localparam logic [2:0] F3_MULH    = 3'b001;
    localparam logic [2:0] F3_MULHSU  = 3'b010;
    localparam logic [2:0] F3_MULHU   = 3'b011;
    localparam logic [2:0] F3_DIV     = 3'b100;
    localparam logic [2:0] F3_DIVU    = 3'b101;
    localparam logic [2:0] F3_REM     = 3'b110;
    localparam logic [2:0] F3_REMU    = 3'b111;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
        ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR,  ALU_AND
    } alu_op_e;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_MUL  = 2'd1;
    localparam logic [1:0] ST_DIV  = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    // alt selects SUB for funct3 000 and SRA for funct3 101
    function automatic alu_op_e f3_to_alu(input logic [2:0] f3, input logic alt);
        case (f3)
            F3_ADD:  return alt ? ALU_SUB : ALU_ADD;
            F3_SLL:  return ALU_SLL;
            F3_SLT:  return ALU_SLT;
            F3_SLTU: return ALU_SLTU;
            F3_XOR:  return ALU_XOR;
            F3_SR:   return alt ? ALU_SRA : ALU_SRL;
            F3_OR:   return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/ex_mdu_alu.sv
`default_nettype none
// ============================================================================
// Module : ex_mdu_alu
// Brief  : Combinational integer ALU for the RV32I/RV64I register/immediate ops.
// Rev    : 1.0
// ============================================================================
module ex_mdu_alu
    import ex_mdu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  alu_op_e         alu_op_i,
    input  logic [XLEN-1:0] op1_i,
    input  logic [XLEN-1:0] op2_i,
    output logic [XLEN-1:0] result_o
);

    localparam int SW = $clog2(XLEN);

    logic [SW-1:0] w_shamt;
    assign w_shamt = op2_i[SW-1:0];

    always_comb begin
        result_o = '0;
        case (alu_op_i)
            ALU_ADD:  result_o = op1_i + op2_i;
            ALU_SUB:  result_o = op1_i - op2_i;
            ALU_SLL:  result_o = op1_i << w_shamt;
            ALU_SLT:  result_o = {{(XLEN-1){1'b0}}, $signed(op1_i) < $signed(op2_i)};
            ALU_SLTU: result_o = {{(XLEN-1){1'b0}}, op1_i < op2_i};
            ALU_XOR:  result_o = op1_i ^ op2_i;
            ALU_SRL:  result_o = op1_i >> w_shamt;
            ALU_SRA:  result_o = $unsigned($signed(op1_i) >>> w_shamt);
            ALU_OR:   result_o = op1_i | op2_i;
            ALU_AND:  result_o = op1_i & op2_i;
            default:  result_o = '0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/ex_mdu_div_iter.sv
`default_nettype none
// ============================================================================
// Module : div_iter
// Brief  : Radix-2 restoring divider, one quotient bit per cycle, sign fixup on output.
// Rev    : 1.0
// ============================================================================
module div_iter #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start_i,
    input  logic            signed_i,
    input  logic            abort_i,
    input  logic [XLEN-1:0] dividend_i,
    input  logic [XLEN-1:0] divisor_i,
    output logic            busy_o,
    output logic            done_o,
    output logic [XLEN-1:0] quotient_o,
    output logic [XLEN-1:0] remainder_o
);

    localparam int              CW     = $clog2(XLEN) + 1;
    localparam logic [CW-1:0]   C_LAST = CW'(XLEN - 1);
    localparam logic [XLEN-1:0] C_MIN  = {1'b1, {(XLEN-1){1'b0}}};

    logic            r_busy;
    logic            r_special;
    logic [CW-1:0]   r_cnt;
    logic [XLEN-1:0] r_quot;
    logic [XLEN-1:0] r_rem;
    logic [XLEN-1:0] r_dvsr;
    logic            r_neg_q;
    logic            r_neg_r;

    logic            w_dvd_neg;
    logic            w_dvs_neg;
    logic            w_div0;
    logic            w_ovf;
    logic [XLEN:0]   w_shift;
    logic [XLEN+1:0] w_diff;
    logic            w_ge;
    logic            w_unused;

    assign w_dvd_neg = signed_i & dividend_i[XLEN-1];
    assign w_dvs_neg = signed_i & divisor_i[XLEN-1];
    assign w_div0    = (divisor_i == '0);
    assign w_ovf     = signed_i && (dividend_i == C_MIN) && (&divisor_i);

    // Shift the next dividend bit into the partial remainder and trial-subtract
    assign w_shift  = {r_rem, r_quot[XLEN-1]};
    assign w_diff   = {1'b0, w_shift} - {2'b00, r_dvsr};
    assign w_ge     = ~w_diff[XLEN+1];
    assign w_unused = w_diff[XLEN];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy    <= 1'b0;
            r_special <= 1'b0;
            r_cnt     <= '0;
            r_quot    <= '0;
            r_rem     <= '0;
            r_dvsr    <= '0;
            r_neg_q   <= 1'b0;
            r_neg_r   <= 1'b0;
        end else if (abort_i) begin
            r_busy <= 1'b0;
            r_cnt  <= '0;
        end else if (start_i) begin
            r_busy <= 1'b1;
            r_cnt  <= '0;
            if (w_div0 || w_ovf) begin
                r_special <= 1'b1;
                r_quot    <= w_div0 ? '1 : dividend_i;
                r_rem     <= w_div0 ? dividend_i : '0;
                r_neg_q   <= 1'b0;
                r_neg_r   <= 1'b0;
            end else begin
                r_special <= 1'b0;
                r_quot    <= w_dvd_neg ? -dividend_i : dividend_i;
                r_rem     <= '0;
                r_dvsr    <= w_dvs_neg ? -divisor_i : divisor_i;
                r_neg_q   <= w_dvd_neg ^ w_dvs_neg;
                r_neg_r   <= w_dvd_neg;
            end
        end else if (r_busy) begin
            if (r_special) begin
                r_busy <= 1'b0;
            end else begin
                r_rem  <= w_ge ? w_diff[XLEN-1:0] : w_shift[XLEN-1:0];
                r_quot <= {r_quot[XLEN-2:0], w_ge};
                if (r_cnt == C_LAST) begin
                    r_busy <= 1'b0;
                    r_cnt  <= '0;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
        end
    end

    assign busy_o      = r_busy;
    assign done_o      = r_busy & (r_special | (r_cnt == C_LAST));
    assign quotient_o  = r_neg_q ? -r_quot : r_quot;
    assign remainder_o = r_neg_r ? -r_rem : r_rem;

endmodule
`default_nettype wire

// File: rtl/ex_mdu.sv
`default_nettype none
// ============================================================================
// Module : ex_mdu
// Brief  : Execute stage: single-cycle integer ALU plus multi-cycle M-extension unit.
// Rev    : 1.0
// ============================================================================
module ex_mdu
    import ex_mdu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [31:0]     inst_i,
    input  logic [31:0]     inst_addr_i,
    input  logic [XLEN-1:0] op1_i,
    input  logic [XLEN-1:0] op2_i,
    input  logic [4:0]      rd_addr_i,
    input  logic            rd_wen_i,
    input  logic            flush_i,
    output logic [4:0]      rd_addr_o,
    output logic [XLEN-1:0] rd_data_o,
    output logic            rd_wen_o,
    output logic            hold_o
);

    logic [6:0]        w_opcode;
    logic [2:0]        w_funct3;
    logic [6:0]        w_funct7;
    logic              w_sh_ok;
    logic              w_int_valid;
    logic              w_m_op;
    alu_op_e           w_alu_op;
    logic [XLEN-1:0]   w_alu_res;

    logic [1:0]        r_state;
    logic [1:0]        w_state_nxt;
    logic [XLEN-1:0]   r_op1;
    logic [XLEN-1:0]   r_op2;
    logic [2:0]        r_funct3;
    logic [2*XLEN-1:0] r_prod;

    logic              w_a_sx;
    logic              w_b_sx;
    logic [2*XLEN-1:0] w_prod;
    logic              w_div_start;
    logic              w_div_busy;
    logic              w_div_done;
    logic [XLEN-1:0]   w_div_q;
    logic [XLEN-1:0]   w_div_r;
    logic [XLEN-1:0]   w_m_result;
    logic              w_unused;

    assign w_opcode = inst_i[6:0];
    assign w_funct3 = inst_i[14:12];
    assign w_funct7 = inst_i[31:25];
    // inst_i[25] is shamt[5] on RV64 and must be clear on RV32
    assign w_sh_ok  = (XLEN == 64) || !inst_i[25];

    always_comb begin
        w_int_valid = 1'b0;
        w_m_op      = 1'b0;
        w_alu_op    = ALU_ADD;
        if (w_opcode == OPC_OP_IMM) begin
            w_alu_op = f3_to_alu(w_funct3, (w_funct3 == F3_SR) && inst_i[30]);
            case (w_funct3)
                F3_SLL:  w_int_valid = (inst_i[31:26] == 6'd0) && w_sh_ok;
                F3_SR:   w_int_valid = ({inst_i[31], inst_i[29:26]} == 5'd0) && w_sh_ok;
                default: w_int_valid = 1'b1;
            endcase
        end else if (w_opcode == OPC_OP) begin
            if (w_funct7 == F7_MULDIV) begin
                w_m_op = 1'b1;
            end else if (w_funct7 == F7_BASE) begin
                w_int_valid = 1'b1;
                w_alu_op    = f3_to_alu(w_funct3, 1'b0);
            end else if (w_funct7 == F7_ALT) begin
                w_int_valid = (w_funct3 == F3_ADD) || (w_funct3 == F3_SR);
                w_alu_op    = f3_to_alu(w_funct3, 1'b1);
            end
        end
    end

    ex_mdu_alu #(.XLEN(XLEN)) u_alu (
        .alu_op_i (w_alu_op),
        .op1_i    (op1_i),
        .op2_i    (op2_i),
        .result_o (w_alu_res)
    );

    // Sign-extend to 2*XLEN so one multiplier covers all four signedness cases
    assign w_a_sx = (r_funct3 != F3_MULHU) & r_op1[XLEN-1];
    assign w_b_sx = ((r_funct3 == F3_MUL) || (r_funct3 == F3_MULH)) & r_op2[XLEN-1];
    assign w_prod = {{XLEN{w_a_sx}}, r_op1} * {{XLEN{w_b_sx}}, r_op2};

    assign w_div_start = (r_state == ST_IDLE) && w_m_op && w_funct3[2] && !flush_i;

    div_iter #(.XLEN(XLEN)) u_div (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_i     (w_div_start),
        .signed_i    (!w_funct3[0]),
        .abort_i     (flush_i),
        .dividend_i  (op1_i),
        .divisor_i   (op2_i),
        .busy_o      (w_div_busy),
        .done_o      (w_div_done),
        .quotient_o  (w_div_q),
        .remainder_o (w_div_r)
    );

    always_comb begin
        w_m_result = w_div_r;
        case (r_funct3)
            F3_MUL:                        w_m_result = r_prod[XLEN-1:0];
            F3_MULH, F3_MULHSU, F3_MULHU:  w_m_result = r_prod[2*XLEN-1:XLEN];
            F3_DIV, F3_DIVU:               w_m_result = w_div_q;
            default:                       w_m_result = w_div_r;
        endcase
    end

    // Special divides still pass through ST_DIV for one cycle: the divider
    // flags completion immediately, giving a uniform two-cycle latency.
    always_comb begin
        w_state_nxt = r_state;
        rd_wen_o    = 1'b0;
        rd_addr_o   = '0;
        rd_data_o   = '0;
        hold_o      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_m_op) begin
                    hold_o      = 1'b1;
                    w_state_nxt = w_funct3[2] ? ST_DIV : ST_MUL;
                end else if (w_int_valid) begin
                    rd_wen_o  = rd_wen_i;
                    rd_addr_o = rd_addr_i;
                    rd_data_o = w_alu_res;
                end
            end
            ST_MUL: begin
                hold_o      = 1'b1;
                w_state_nxt = ST_DONE;
            end
            ST_DIV: begin
                hold_o = 1'b1;
                if (w_div_done) begin
                    w_state_nxt = ST_DONE;
                end
            end
            default: begin
                rd_wen_o    = rd_wen_i;
                rd_addr_o   = rd_addr_i;
                rd_data_o   = w_m_result;
                w_state_nxt = ST_IDLE;
            end
        endcase
        if (flush_i) begin
            rd_wen_o    = 1'b0;
            hold_o      = 1'b0;
            w_state_nxt = ST_IDLE;
        end
        if (!rst_n) begin
            rd_wen_o  = 1'b0;
            rd_addr_o = '0;
            rd_data_o = '0;
            hold_o    = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_op1    <= '0;
            r_op2    <= '0;
            r_funct3 <= '0;
            r_prod   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if ((r_state == ST_IDLE) && w_m_op && !flush_i) begin
                r_op1    <= op1_i;
                r_op2    <= op2_i;
                r_funct3 <= w_funct3;
            end
            if (r_state == ST_MUL) begin
                r_prod <= w_prod;
            end
        end
    end

    assign w_unused = ^{inst_addr_i, inst_i[24:15], inst_i[11:7], w_div_busy};

endmodule
`default_nettype wire

// File: tb/tb_ex_mdu.sv
`default_nettype none
// ============================================================================
// Module : tb_ex_mdu
// Brief  : Directed self-checking bench for ex_mdu (XLEN=32).
// Rev    : 1.0
// ============================================================================
module tb_ex_mdu;

    localparam logic [6:0] C_OP  = 7'b0110011;
    localparam logic [6:0] C_IMM = 7'b0010011;
    localparam logic [6:0] C_M   = 7'b0000001;

    logic        clk;
    logic        rst_n;
    logic [31:0] inst_i;
    logic [31:0] inst_addr_i;
    logic [31:0] op1_i;
    logic [31:0] op2_i;
    logic [4:0]  rd_addr_i;
    logic        rd_wen_i;
    logic        flush_i;
    logic [4:0]  rd_addr_o;
    logic [31:0] rd_data_o;
    logic        rd_wen_o;
    logic        hold_o;

    int n_cmp;
    int n_fail;

    logic [31:0] v_inst [16];
    logic [31:0] v_a    [16];
    logic [31:0] v_b    [16];
    logic [31:0] v_exp  [16];
    logic        v_wen  [16];
    int          v_lat  [16];

    ex_mdu #(.XLEN(32)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .inst_i      (inst_i),
        .inst_addr_i (inst_addr_i),
        .op1_i       (op1_i),
        .op2_i       (op2_i),
        .rd_addr_i   (rd_addr_i),
        .rd_wen_i    (rd_wen_i),
        .flush_i     (flush_i),
        .rd_addr_o   (rd_addr_o),
        .rd_data_o   (rd_data_o),
        .rd_wen_o    (rd_wen_o),
        .hold_o      (hold_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] enc(input logic [6:0] f7, input logic [2:0] f3,
                                        input logic [6:0] opc);
        return {f7, 5'd2, 5'd1, f3, 5'd9, opc};
    endfunction

    // Issue an M-op and follow it until the write; inputs stay stable meanwhile
    task automatic run_mop(input logic [31:0] inst, input logic [31:0] a, input logic [31:0] b,
                           output int lat, output int holds, output logic [31:0] data,
                           output logic [4:0] addr);
        inst_i = inst; op1_i = a; op2_i = b; rd_addr_i = 5'd9; rd_wen_i = 1'b1;
        #1;
        lat = -1; holds = 0; data = '0; addr = '0;
        if (hold_o) holds++;
        if (rd_wen_o) begin lat = 0; data = rd_data_o; addr = rd_addr_o; end
        for (int i = 1; i <= 60 && lat < 0; i++) begin
            @(negedge clk); #1;
            if (hold_o) holds++;
            if (rd_wen_o) begin lat = i; data = rd_data_o; addr = rd_addr_o; end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; flush_i = 1'b0; inst_addr_i = 32'h100;
        inst_i = enc(7'h00, 3'b000, C_IMM); op1_i = 32'd5; op2_i = 32'd3;
        rd_addr_i = 5'd7; rd_wen_i = 1'b1;
        #1;
        n_cmp += 4;
        if (rd_wen_o !== 1'b0) begin n_fail++; $display("FAIL reset_wen: got %b want 0", rd_wen_o); end
        if (hold_o !== 1'b0) begin n_fail++; $display("FAIL reset_hold: got %b want 0", hold_o); end
        if (rd_addr_o !== 5'd0) begin n_fail++; $display("FAIL reset_addr: got %0d want 0", rd_addr_o); end
        if (rd_data_o !== 32'd0) begin n_fail++; $display("FAIL reset_data: got %h want 0", rd_data_o); end
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_int_ops();
        v_inst[0]  = enc(7'h7F, 3'b000, C_IMM); v_a[0]  = 32'd5;        v_b[0]  = 32'hFFFFFFF9; v_exp[0]  = 32'hFFFFFFFE; v_wen[0]  = 1;
        v_inst[1]  = enc(7'h20, 3'b101, C_IMM); v_a[1]  = 32'h80000000; v_b[1]  = 32'd4;        v_exp[1]  = 32'hF8000000; v_wen[1]  = 1;
        v_inst[2]  = enc(7'h00, 3'b101, C_IMM); v_a[2]  = 32'h80000000; v_b[2]  = 32'd4;        v_exp[2]  = 32'h08000000; v_wen[2]  = 1;
        v_inst[3]  = enc(7'h20, 3'b000, C_OP);  v_a[3]  = 32'd10;       v_b[3]  = 32'd3;        v_exp[3]  = 32'd7;        v_wen[3]  = 1;
        v_inst[4]  = enc(7'h00, 3'b010, C_OP);  v_a[4]  = 32'hFFFFFFFF; v_b[4]  = 32'd1;        v_exp[4]  = 32'd1;        v_wen[4]  = 1;
        v_inst[5]  = enc(7'h00, 3'b011, C_OP);  v_a[5]  = 32'hFFFFFFFF; v_b[5]  = 32'd1;        v_exp[5]  = 32'd0;        v_wen[5]  = 1;
        v_inst[6]  = enc(7'h00, 3'b100, C_OP);  v_a[6]  = 32'hF0F0F0F0; v_b[6]  = 32'hFF00FF00; v_exp[6]  = 32'h0FF00FF0; v_wen[6]  = 1;
        v_inst[7]  = enc(7'h00, 3'b110, C_OP);  v_a[7]  = 32'hF0F0F0F0; v_b[7]  = 32'hFF00FF00; v_exp[7]  = 32'hFFF0FFF0; v_wen[7]  = 1;
        v_inst[8]  = enc(7'h00, 3'b111, C_OP);  v_a[8]  = 32'hF0F0F0F0; v_b[8]  = 32'hFF00FF00; v_exp[8]  = 32'hF000F000; v_wen[8]  = 1;
        v_inst[9]  = enc(7'h00, 3'b001, C_OP);  v_a[9]  = 32'd1;        v_b[9]  = 32'h25;       v_exp[9]  = 32'h20;       v_wen[9]  = 1;
        v_inst[10] = enc(7'h20, 3'b101, C_OP);  v_a[10] = 32'h80000000; v_b[10] = 32'd31;       v_exp[10] = 32'hFFFFFFFF; v_wen[10] = 1;
        v_inst[11] = enc(7'h00, 3'b011, C_IMM); v_a[11] = 32'd3;        v_b[11] = 32'd5;        v_exp[11] = 32'd1;        v_wen[11] = 1;
        v_inst[12] = enc(7'h00, 3'b000, 7'h7F); v_a[12] = 32'd3;        v_b[12] = 32'd5;        v_exp[12] = 32'd0;        v_wen[12] = 0;
        v_inst[13] = enc(7'h20, 3'b001, C_OP);  v_a[13] = 32'd3;        v_b[13] = 32'd5;        v_exp[13] = 32'd0;        v_wen[13] = 0;
        v_inst[14] = enc(7'h01, 3'b001, C_IMM); v_a[14] = 32'd3;        v_b[14] = 32'd5;        v_exp[14] = 32'd0;        v_wen[14] = 0;
        v_inst[15] = enc(7'h00, 3'b010, C_IMM); v_a[15] = 32'hFFFFFFF0; v_b[15] = 32'd1;        v_exp[15] = 32'd1;        v_wen[15] = 1;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            inst_i = v_inst[i]; op1_i = v_a[i]; op2_i = v_b[i];
            rd_addr_i = 5'(i + 1); rd_wen_i = 1'b1;
            #1;
            n_cmp += 4;
            if (rd_data_o !== v_exp[i]) begin n_fail++; $display("FAIL int_data[%0d]: got %h want %h", i, rd_data_o, v_exp[i]); end
            if (rd_wen_o !== v_wen[i]) begin n_fail++; $display("FAIL int_wen[%0d]: got %b want %b", i, rd_wen_o, v_wen[i]); end
            if (hold_o !== 1'b0) begin n_fail++; $display("FAIL int_hold[%0d]: got %b want 0", i, hold_o); end
            if (rd_addr_o !== (v_wen[i] ? 5'(i + 1) : 5'd0)) begin
                n_fail++; $display("FAIL int_addr[%0d]: got %0d want %0d", i, rd_addr_o, v_wen[i] ? i + 1 : 0);
            end
        end
    endtask

    task automatic test_mdu_ops();
        int lat, holds;
        logic [31:0] data;
        logic [4:0]  addr;
        v_inst[0]  = enc(C_M, 3'b001, C_OP); v_a[0]  = 32'h80000000; v_b[0]  = 32'd2;        v_exp[0]  = 32'hFFFFFFFF; v_lat[0]  = 2;
        v_inst[1]  = enc(C_M, 3'b011, C_OP); v_a[1]  = 32'hFFFFFFFF; v_b[1]  = 32'hFFFFFFFF; v_exp[1]  = 32'hFFFFFFFE; v_lat[1]  = 2;
        v_inst[2]  = enc(C_M, 3'b010, C_OP); v_a[2]  = 32'hFFFFFFFF; v_b[2]  = 32'hFFFFFFFF; v_exp[2]  = 32'hFFFFFFFF; v_lat[2]  = 2;
        v_inst[3]  = enc(C_M, 3'b001, C_OP); v_a[3]  = 32'hFFFFFFFF; v_b[3]  = 32'hFFFFFFFF; v_exp[3]  = 32'd0;        v_lat[3]  = 2;
        v_inst[4]  = enc(C_M, 3'b000, C_OP); v_a[4]  = 32'hFFFFFFFF; v_b[4]  = 32'hFFFFFFFF; v_exp[4]  = 32'd1;        v_lat[4]  = 2;
        v_inst[5]  = enc(C_M, 3'b100, C_OP); v_a[5]  = 32'hFFFFFFF9; v_b[5]  = 32'd2;        v_exp[5]  = 32'hFFFFFFFD; v_lat[5]  = 33;
        v_inst[6]  = enc(C_M, 3'b110, C_OP); v_a[6]  = 32'hFFFFFFF9; v_b[6]  = 32'd2;        v_exp[6]  = 32'hFFFFFFFF; v_lat[6]  = 33;
        v_inst[7]  = enc(C_M, 3'b101, C_OP); v_a[7]  = 32'd100;      v_b[7]  = 32'd7;        v_exp[7]  = 32'd14;       v_lat[7]  = 33;
        v_inst[8]  = enc(C_M, 3'b111, C_OP); v_a[8]  = 32'd100;      v_b[8]  = 32'd7;        v_exp[8]  = 32'd2;        v_lat[8]  = 33;
        v_inst[9]  = enc(C_M, 3'b100, C_OP); v_a[9]  = 32'd7;        v_b[9]  = 32'hFFFFFFFE; v_exp[9]  = 32'hFFFFFFFD; v_lat[9]  = 33;
        v_inst[10] = enc(C_M, 3'b110, C_OP); v_a[10] = 32'd7;        v_b[10] = 32'hFFFFFFFE; v_exp[10] = 32'd1;        v_lat[10] = 33;
        v_inst[11] = enc(C_M, 3'b101, C_OP); v_a[11] = 32'd9;        v_b[11] = 32'd0;        v_exp[11] = 32'hFFFFFFFF; v_lat[11] = 2;
        v_inst[12] = enc(C_M, 3'b100, C_OP); v_a[12] = 32'h80000000; v_b[12] = 32'hFFFFFFFF; v_exp[12] = 32'h80000000; v_lat[12] = 2;
        v_inst[13] = enc(C_M, 3'b110, C_OP); v_a[13] = 32'h80000000; v_b[13] = 32'hFFFFFFFF; v_exp[13] = 32'd0;        v_lat[13] = 2;
        v_inst[14] = enc(C_M, 3'b110, C_OP); v_a[14] = 32'h00001234; v_b[14] = 32'd0;        v_exp[14] = 32'h00001234; v_lat[14] = 2;
        v_inst[15] = enc(C_M, 3'b000, C_OP); v_a[15] = 32'd7;        v_b[15] = 32'd6;        v_exp[15] = 32'd42;       v_lat[15] = 2;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            run_mop(v_inst[i], v_a[i], v_b[i], lat, holds, data, addr);
            n_cmp += 4;
            if (lat != v_lat[i]) begin n_fail++; $display("FAIL mdu_latency[%0d]: got %0d want %0d", i, lat, v_lat[i]); end
            if (data !== v_exp[i]) begin n_fail++; $display("FAIL mdu_data[%0d]: got %h want %h", i, data, v_exp[i]); end
            if (holds != v_lat[i]) begin n_fail++; $display("FAIL mdu_hold_cycles[%0d]: got %0d want %0d", i, holds, v_lat[i]); end
            if (addr !== 5'd9) begin n_fail++; $display("FAIL mdu_addr[%0d]: got %0d want 9", i, addr); end
        end
    endtask

    task automatic test_back_to_back();
        int lat, holds;
        logic [31:0] data;
        logic [4:0]  addr;
        @(negedge clk);
        run_mop(enc(C_M, 3'b101, C_OP), 32'd50, 32'd5, lat, holds, data, addr);
        n_cmp++;
        if (data !== 32'd10) begin n_fail++; $display("FAIL b2b_div: got %h want %h", data, 32'd10); end
        @(negedge clk);
        inst_i = enc(7'h00, 3'b000, C_IMM); op1_i = 32'd1; op2_i = 32'd1; rd_addr_i = 5'd4;
        #1;
        n_cmp += 2;
        if (rd_data_o !== 32'd2 || rd_wen_o !== 1'b1) begin
            n_fail++; $display("FAIL b2b_addi: got data %h wen %b want 2/1", rd_data_o, rd_wen_o);
        end
        if (hold_o !== 1'b0) begin n_fail++; $display("FAIL b2b_hold: got %b want 0", hold_o); end
    endtask

    task automatic test_flush();
        int bad;
        @(negedge clk);
        inst_i = enc(C_M, 3'b101, C_OP); op1_i = 32'd100; op2_i = 32'd7; rd_addr_i = 5'd9; rd_wen_i = 1'b1;
        for (int i = 0; i < 10; i++) @(negedge clk);
        flush_i = 1'b1;
        #1;
        n_cmp += 2;
        if (hold_o !== 1'b0) begin n_fail++; $display("FAIL flush_div_hold: got %b want 0", hold_o); end
        if (rd_wen_o !== 1'b0) begin n_fail++; $display("FAIL flush_div_wen: got %b want 0", rd_wen_o); end
        @(negedge clk);
        flush_i = 1'b0;
        inst_i = enc(7'h00, 3'b000, C_OP); op1_i = 32'd3; op2_i = 32'd4; rd_addr_i = 5'd5;
        #1;
        n_cmp += 3;
        if (rd_data_o !== 32'd7) begin n_fail++; $display("FAIL flush_add_data: got %h want 7", rd_data_o); end
        if (rd_wen_o !== 1'b1) begin n_fail++; $display("FAIL flush_add_wen: got %b want 1", rd_wen_o); end
        if (hold_o !== 1'b0) begin n_fail++; $display("FAIL flush_add_hold: got %b want 0", hold_o); end
        @(negedge clk);
        inst_i = 32'd0;
        bad = 0;
        for (int i = 0; i < 40; i++) begin
            #1;
            if (rd_wen_o !== 1'b0 || hold_o !== 1'b0) bad++;
            @(negedge clk);
        end
        n_cmp++;
        if (bad != 0) begin n_fail++; $display("FAIL flush_discard: got %0d active cycles want 0", bad); end
        // Flush landing on the completion cycle must suppress the write
        inst_i = enc(C_M, 3'b101, C_OP); op1_i = 32'd9; op2_i = 32'd0;
        @(negedge clk); @(negedge clk);
        flush_i = 1'b1;
        #1;
        n_cmp++;
        if (rd_wen_o !== 1'b0) begin n_fail++; $display("FAIL flush_done_wen: got %b want 0", rd_wen_o); end
        @(negedge clk);
        flush_i = 1'b0; inst_i = 32'd0;
        #1;
        n_cmp++;
        if (rd_wen_o !== 1'b0 || hold_o !== 1'b0) begin
            n_fail++; $display("FAIL flush_done_after: got wen %b hold %b want 0/0", rd_wen_o, hold_o);
        end
    endtask

    task automatic test_reset_mid_div();
        int bad;
        @(negedge clk);
        inst_i = enc(C_M, 3'b100, C_OP); op1_i = 32'hFFFFFFF9; op2_i = 32'd2; rd_addr_i = 5'd9;
        for (int i = 0; i < 5; i++) @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_cmp += 3;
        if (hold_o !== 1'b0) begin n_fail++; $display("FAIL rstdiv_hold: got %b want 0", hold_o); end
        if (rd_wen_o !== 1'b0) begin n_fail++; $display("FAIL rstdiv_wen: got %b want 0", rd_wen_o); end
        if (rd_data_o !== 32'd0 || rd_addr_o !== 5'd0) begin
            n_fail++; $display("FAIL rstdiv_outputs: got data %h addr %0d want 0/0", rd_data_o, rd_addr_o);
        end
        inst_i = 32'd0;
        @(negedge clk);
        rst_n = 1'b1;
        bad = 0;
        for (int i = 0; i < 40; i++) begin
            #1;
            if (rd_wen_o !== 1'b0 || hold_o !== 1'b0) bad++;
            @(negedge clk);
        end
        n_cmp++;
        if (bad != 0) begin n_fail++; $display("FAIL rstdiv_no_write: got %0d active cycles want 0", bad); end
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        test_reset();
        test_int_ops();
        test_mdu_ops();
        test_back_to_back();
        test_flush();
        test_reset_mid_div();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
